// File: rtl/ysyx_22041412_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier for the EXU M-extension path.
// Optional early termination: define YSYX_MUL_EARLY_OUT_EN.
module ysyx_22041412_booth_mul_iter #(
  parameter int XLEN           = 64,
  parameter int DIGITS_PER_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic            op_w,
  input  logic            hi_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int NDIG = XLEN / 2 + 1;
  localparam int ITER = (NDIG + DIGITS_PER_CYC - 1) / DIGITS_PER_CYC;
  localparam int AW   = 2 * XLEN + 2;
  localparam int MW   = XLEN + 3;
  localparam int HW   = XLEN / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int SH   = 2 * DIGITS_PER_CYC;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]   acc, acc_nxt, mcand, pp_sum, sh;
  logic [MW-1:0]   mplier, mplier_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN+1:0] a_ext, b_ext;
  logic [2:0]      win;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] res_nxt;
  logic            w_q, hi_q;
  logic            accept, early, last;
  logic            unused_bits;

  assign in_ready  = (state == IDLE) & ~flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;

  // Operand extension to XLEN+2 bits, word ops use the low half only
  always_comb begin
    if (op_w) begin
      a_ext = {{(HW + 2){a_signed & a[HW-1]}}, a[HW-1:0]};
      b_ext = {{(HW + 2){b_signed & b[HW-1]}}, b[HW-1:0]};
    end else begin
      a_ext = {{2{a_signed & a[XLEN-1]}}, a};
      b_ext = {{2{b_signed & b[XLEN-1]}}, b};
    end
  end

  // Sum of this cycle's Booth partial products
  always_comb begin
    pp_sum = '0;
    win    = '0;
    sh     = '0;
    for (int d = 0; d < DIGITS_PER_CYC; d++) begin
      win = mplier[2*d +: 3];
      sh  = mcand << (2 * d);
      case (win)
        3'b001, 3'b010: pp_sum = pp_sum + sh;
        3'b011:         pp_sum = pp_sum + (sh << 1);
        3'b100:         pp_sum = pp_sum - (sh << 1);
        3'b101, 3'b110: pp_sum = pp_sum - sh;
        default:        pp_sum = pp_sum;
      endcase
    end
    acc_nxt = acc + pp_sum;
  end

  // Arithmetic shift keeps surplus digits at zero weight
  assign mplier_nxt = $signed(mplier) >>> SH;

`ifdef YSYX_MUL_EARLY_OUT_EN
  assign early = (mplier_nxt == '0) | (&mplier_nxt);
`else
  assign early = 1'b0;
`endif

  assign last = (cnt == CW'(ITER - 1)) | early;

  // Result selection from the final accumulator value
  always_comb begin
    prod = acc_nxt[2*XLEN-1:0];
    if (w_q) begin
      res_nxt = {{HW{prod[HW-1]}}, prod[HW-1:0]};
    end else if (hi_q) begin
      res_nxt = prod[2*XLEN-1:XLEN];
    end else begin
      res_nxt = prod[XLEN-1:0];
    end
  end

  assign unused_bits = ^acc_nxt[AW-1:2*XLEN];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, flush wins over everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: load on accept, iterate in CALC, capture result on last step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      w_q    <= 1'b0;
      hi_q   <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{XLEN{a_ext[XLEN+1]}}, a_ext};
      mplier <= {b_ext, 1'b0};
      cnt    <= '0;
      w_q    <= op_w;
      hi_q   <= hi_sel;
    end else if (state == CALC && !flush) begin
      acc    <= acc_nxt;
      mcand  <= mcand << SH;
      mplier <= mplier_nxt;
      cnt    <= cnt + CW'(1);
      if (last) result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_booth_mul_iter.sv
// Randomised self-checking bench for the Booth multiplier.
// Reference: wide two's-complement multiply of the extended operands.
module tb_ysyx_22041412_booth_mul_iter;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [63:0] a, b, result;
  logic        a_signed, b_signed, op_w, hi_sel;
  logic        out_valid, out_ready, busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_22041412_booth_mul_iter #(
    .XLEN(64),
    .DIGITS_PER_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .a_signed(a_signed),
    .b_signed(b_signed),
    .op_w(op_w),
    .hi_sel(hi_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(
    input logic [63:0] x, input logic [63:0] y,
    input logic xs, input logic ys, input logic w, input logic hi);
    logic signed [129:0] ex, ey, p;
    if (w) begin
      ex = xs ? {{98{x[31]}}, x[31:0]} : {98'b0, x[31:0]};
      ey = ys ? {{98{y[31]}}, y[31:0]} : {98'b0, y[31:0]};
    end else begin
      ex = xs ? {{66{x[63]}}, x} : {66'b0, x};
      ey = ys ? {{66{y[63]}}, y} : {66'b0, y};
    end
    p = ex * ey;
    if (w) return {{32{p[31]}}, p[31:0]};
    return hi ? p[127:64] : p[63:0];
  endfunction

  task automatic start_op(input logic [63:0] x, input logic [63:0] y,
                          input logic xs, input logic ys,
                          input logic w, input logic hi);
    a = x; b = y; a_signed = xs; b_signed = ys;
    op_w = w; hi_sel = hi; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    a_signed = 1'($urandom);
    b_signed = 1'($urandom);
    op_w = 1'($urandom);
    hi_sel = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("timeout", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic xs, input logic ys,
                        input logic w, input logic hi,
                        output int lat);
    logic [63:0] exp;
    exp = ref_mul(x, y, xs, ys, w, hi);
    start_op(x, y, xs, ys, w, hi);
    wait_done(lat);
    check(tag, result, exp);
    take();
  endtask

  initial begin
    int lat, seen;
    logic [63:0] held;
    logic [63:0] x, y;
    logic xs, ys, w, hi;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    op_w = 1'b0; hi_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    run_op("mul_3x5", 64'd3, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    check("mul_3x5_15", result, 64'd15);
`ifdef YSYX_MUL_EARLY_OUT_EN
    check("lat_le_18", {63'b0, lat <= 18}, 64'd1);
`else
    check("lat_18", 64'(lat), 64'd18);
`endif

    run_op("mulh_m1", '1, '1, 1'b1, 1'b1, 1'b0, 1'b1, lat);
    check("mulh_m1_0", result, 64'd0);
    run_op("mul_m1", '1, '1, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    check("mul_m1_1", result, 64'd1);
    run_op("mulhu", '1, '1, 1'b0, 1'b0, 1'b0, 1'b1, lat);
    check("mulhu_c", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu", 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000,
           1'b1, 1'b0, 1'b0, 1'b1, lat);
    check("mulhsu_c", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
           1'b1, 1'b1, 1'b1, 1'b1, lat);
    check("mulw_c", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Back-pressure in DONE
    start_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(lat);
    held = result;
    check("stall_val", held,
          ref_mul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  1'b1, 1'b0, 1'b0, 1'b1));
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("stall_out_valid", {63'b0, out_valid}, 64'd1);
      check("stall_result", result, held);
    end
    in_valid = 1'b0;
    take();
    check("after_hs_busy", {63'b0, busy}, 64'd0);

    // Flush mid-CALC while a new request is offered
    start_op(64'd123456789, 64'd987654321, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    a = 64'd11; b = 64'd13;
    check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_silent", 64'(seen), 64'd0);
    run_op("after_flush", 64'd6, 64'd7, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    check("after_flush_42", result, 64'd42);

    // Early-out latency
    run_op("early_9x1", 64'd9, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0, lat);
`ifdef YSYX_MUL_EARLY_OUT_EN
    check("early_lat", {63'b0, lat <= 3}, 64'd1);
`else
    check("fixed_lat", 64'(lat), 64'd18);
`endif

    // Randomised ops against the reference model
    for (int i = 0; i < 40; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 8 == 1) y = 64'($urandom_range(0, 3));
      if (i % 8 == 2) y = ~64'($urandom_range(0, 3));
      xs = 1'($urandom); ys = 1'($urandom);
      w = (i % 4 == 3); hi = 1'($urandom);
      if (i % 3 == 0) begin xs = 1'b1; ys = 1'b1; end
      run_op($sformatf("rand%0d", i), x, y, xs, ys, w, hi, lat);
    end

    // Reset in the middle of an operation clears the result
    check("pre_rst_result_nz", {63'b0, result != 0}, 64'd1);
    start_op(64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_result", result, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
